// File: rtl/calendar_edit_controller.sv
// calendar_edit_controller: debounces the five buttons, runs the RUN/EDIT mode FSM,
// selects the field under edit and emits plus/minus strokes with auto-repeat and blink.
module calendar_edit_controller #(
   parameter int DEBOUNCE_MS     = 20,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100,
   parameter int BLINK_HALF_MS   = 250,
   parameter int TIMEOUT_MS      = 10000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_tick_1ms,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_left,
   input  logic       i_right,
   input  logic       i_control,
   output logic [4:0] o_state,
   output logic       o_is_modify,
   output logic       o_plus,
   output logic       o_minus,
   output logic       o_blank
);
   localparam int DW = $clog2(DEBOUNCE_MS) + 1;
   localparam int RMAX = REPEAT_DELAY_MS > REPEAT_RATE_MS ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
   localparam int RW = $clog2(RMAX) + 1;
   localparam int BW = $clog2(BLINK_HALF_MS) + 1;
   localparam int TW = $clog2(TIMEOUT_MS) + 1;
   typedef enum logic {RUN, EDIT} mode_t;
   // button bit order: 0 up, 1 down, 2 left, 3 right, 4 control
   logic [4:0] raw, sync1_q, sync2_q, lvl_q, lvl_d, lvl_dly_q, press;
   logic [4:0][DW-1:0] db_cnt_q, db_cnt_d;
   mode_t mode_q, mode_d;
   logic [2:0] field_q, field_d;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic rep_run_q, rep_run_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic phase_q, phase_d;
   logic [TW-1:0] idle_q, idle_d;
   logic plus_q, plus_d, minus_q, minus_d;
   logic edit, any_press, one_held, rep_fire, timeout, stroke_en;

   assign raw = {i_control, i_right, i_left, i_down, i_up};
   assign press = lvl_q & ~lvl_dly_q;

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         lvl_d[i] = lvl_q[i];
         db_cnt_d[i] = db_cnt_q[i];
         if (sync2_q[i] == lvl_q[i]) db_cnt_d[i] = '0;
         else if (i_tick_1ms) begin
            if (db_cnt_q[i] == DW'(DEBOUNCE_MS - 1)) begin
               lvl_d[i] = sync2_q[i];
               db_cnt_d[i] = '0;
            end else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      edit = mode_q == EDIT;
      any_press = |press;
      one_held = lvl_q[0] ^ lvl_q[1];
      rep_fire = edit & one_held & i_tick_1ms & ~press[0] & ~press[1] &
                 (rep_cnt_q == (rep_run_q ? RW'(REPEAT_RATE_MS - 1) : RW'(REPEAT_DELAY_MS - 1)));
      timeout = edit & i_tick_1ms & ~any_press & ~rep_fire & (idle_q == TW'(TIMEOUT_MS - 1));
      stroke_en = edit & ~press[4] & ~timeout;
      plus_d = stroke_en & lvl_q[0] & ~lvl_q[1] & (press[0] | rep_fire);
      minus_d = stroke_en & lvl_q[1] & ~lvl_q[0] & (press[1] | rep_fire);
      mode_d = mode_q;
      field_d = field_q;
      if (!edit) begin
         mode_d = press[4] ? EDIT : RUN;
         field_d = '0;
      end else if (press[4] || timeout) begin
         mode_d = RUN;
         field_d = '0;
      end else if (press[3] && !press[2]) field_d = field_q == 3'd6 ? 3'd0 : field_q + 3'd1;
      else if (press[2] && !press[3]) field_d = field_q == 3'd0 ? 3'd6 : field_q - 3'd1;
      rep_cnt_d = rep_cnt_q;
      rep_run_d = rep_run_q;
      if (!edit || !one_held || press[0] || press[1] || press[4]) begin
         rep_cnt_d = '0;
         rep_run_d = 1'b0;
      end else if (rep_fire) begin
         rep_cnt_d = '0;
         rep_run_d = 1'b1;
      end else if (i_tick_1ms) rep_cnt_d = rep_cnt_q + 1'b1;
      blink_cnt_d = blink_cnt_q;
      phase_d = phase_q;
      if (!edit || any_press) begin
         blink_cnt_d = '0;
         phase_d = 1'b0;
      end else if (i_tick_1ms) begin
         if (blink_cnt_q == BW'(BLINK_HALF_MS - 1)) begin
            blink_cnt_d = '0;
            phase_d = ~phase_q;
         end else blink_cnt_d = blink_cnt_q + 1'b1;
      end
      idle_d = idle_q;
      if (!edit || any_press || plus_d || minus_d || timeout) idle_d = '0;
      else if (i_tick_1ms) idle_d = idle_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q <= '0;
         lvl_dly_q <= '0;
         db_cnt_q <= '0;
         mode_q <= RUN;
         field_q <= '0;
         rep_cnt_q <= '0;
         rep_run_q <= 1'b0;
         blink_cnt_q <= '0;
         phase_q <= 1'b0;
         idle_q <= '0;
         plus_q <= 1'b0;
         minus_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         lvl_q <= lvl_d;
         lvl_dly_q <= lvl_q;
         db_cnt_q <= db_cnt_d;
         mode_q <= mode_d;
         field_q <= field_d;
         rep_cnt_q <= rep_cnt_d;
         rep_run_q <= rep_run_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q <= phase_d;
         idle_q <= idle_d;
         plus_q <= plus_d;
         minus_q <= minus_d;
      end
   end

   assign o_state = {2'b00, field_q};
   assign o_is_modify = edit;
   assign o_plus = plus_q;
   assign o_minus = minus_q;
   assign o_blank = edit & phase_q;
endmodule

// File: tb/tb_calendar_edit_controller.sv
// tb_calendar_edit_controller: scoreboard bench; expected strokes are queued with the tick
// they must appear on and checked as the DUT emits them.
module tb_calendar_edit_controller;
   typedef struct {int kind; int tick;} exp_t;
   logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
   logic [4:0] btn = '0;
   logic [4:0] o_state;
   logic o_is_modify, o_plus, o_minus, o_blank;
   int tick_num = 0, div = 0, n_checks = 0, n_fail = 0, t = 0;
   exp_t exp_q[$];
   exp_t e;

   calendar_edit_controller #(
      .DEBOUNCE_MS(3), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(4), .BLINK_HALF_MS(5), .TIMEOUT_MS(50)
   ) dut (
      .clk(clk), .reset(reset), .i_tick_1ms(tick),
      .i_up(btn[0]), .i_down(btn[1]), .i_left(btn[2]), .i_right(btn[3]), .i_control(btn[4]),
      .o_state(o_state), .o_is_modify(o_is_modify), .o_plus(o_plus), .o_minus(o_minus), .o_blank(o_blank)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tick) tick_num <= tick_num + 1;
      div <= (div == 4) ? 0 : div + 1;
      tick <= (div == 4);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tick %0d)", tag, got, exp, tick_num);
      end
   endtask

   task automatic push_exp(input int kind, input int at);
      exp_q.push_back('{kind: kind, tick: at});
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic press_btn(input logic [4:0] m);
      wait_ticks(1);
      btn = m;
      wait_ticks(3);
      btn = '0;
      wait_ticks(3);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (o_plus || o_minus) begin
         if (exp_q.size() == 0) check("stroke_unexpected", int'({o_minus, o_plus}), 0);
         else begin
            e = exp_q.pop_front();
            check("stroke_kind", int'({o_minus, o_plus}), e.kind);
            check("stroke_tick", tick_num, e.tick);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d expected strokes pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_state", int'(o_state), 0);
      check("rst_modify", int'(o_is_modify), 0);
      check("rst_plus", int'(o_plus), 0);
      check("rst_minus", int'(o_minus), 0);
      check("rst_blank", int'(o_blank), 0);
      reset = 1'b1;
      wait_ticks(1);
      btn[4] = 1'b1;
      wait_ticks(1);
      btn[4] = 1'b0;
      wait_ticks(1);
      btn[4] = 1'b1;
      wait_ticks(2);
      repeat (3) @(negedge clk);
      check("bounce_early", int'(o_is_modify), 0);
      wait_ticks(1);
      repeat (3) @(negedge clk);
      check("bounce_edit", int'(o_is_modify), 1);
      check("bounce_state", int'(o_state), 0);
      btn[4] = 1'b0;
      wait_ticks(4);
      check("bounce_single", int'(o_is_modify), 1);
      press_btn(5'b00100);
      check("wrap_left", int'(o_state), 6);
      press_btn(5'b01000);
      check("wrap_right", int'(o_state), 0);
      press_btn(5'b01000);
      check("right_again", int'(o_state), 1);
      press_btn(5'b01100);
      check("left_right_same", int'(o_state), 1);
      wait_ticks(1);
      t = tick_num;
      btn[0] = 1'b1;
      push_exp(1, t + 3);
      for (int k = 13; k <= 33; k += 4) push_exp(1, t + k);
      wait_ticks(33);
      btn[0] = 1'b0;
      wait_ticks(4);
      check("repeat_pending", exp_q.size(), 0);
      wait_ticks(1);
      t = tick_num;
      btn[1:0] = 2'b11;
      wait_ticks(20);
      check("conflict_pending", exp_q.size(), 0);
      btn[1] = 1'b0;
      push_exp(1, t + 33);
      wait_ticks(13);
      btn[0] = 1'b0;
      wait_ticks(4);
      check("conflict_restart_pending", exp_q.size(), 0);
      press_btn(5'b10000);
      check("exit_modify", int'(o_is_modify), 0);
      check("exit_state", int'(o_state), 0);
      wait_ticks(1);
      btn[4] = 1'b1;
      wait_ticks(3);
      btn[4] = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         wait_ticks(1);
         @(negedge clk);
         check($sformatf("blink_%0d", k), int'(o_blank), (k < 50 && (k / 5) % 2 == 1) ? 1 : 0);
         check($sformatf("timeout_modify_%0d", k), int'(o_is_modify), k < 50 ? 1 : 0);
      end
      press_btn(5'b10000);
      check("reenter_modify", int'(o_is_modify), 1);
      repeat (4) press_btn(5'b01000);
      check("field_four", int'(o_state), 4);
      wait_ticks(1);
      t = tick_num;
      btn[0] = 1'b1;
      push_exp(1, t + 3);
      wait_ticks(5);
      #2;
      reset = 1'b0;
      #1;
      check("async_state", int'(o_state), 0);
      check("async_modify", int'(o_is_modify), 0);
      check("async_plus", int'(o_plus), 0);
      check("async_minus", int'(o_minus), 0);
      check("async_blank", int'(o_blank), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wait_ticks(20);
      check("post_reset_modify", int'(o_is_modify), 0);
      check("post_reset_state", int'(o_state), 0);
      btn[0] = 1'b0;
      wait_ticks(4);
      check("final_pending", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
